// File: rtl/clk_rst_seq_if.sv
// ---------------------------------------------------------------------------
// clk_rst_seq_if
// Bundle of the startup sequencer's lock input and reset/tick outputs.
//   locked     : MMCM lock (asynchronous to the sequencer clock)
//   rst_dom_n  : per-domain active-low resets, NUM_DOM wide
//   ready      : all domains released
//   ce_out     : one-cycle slow-logic enable strobe
//   lock_lost  : sticky flag, lock dropped after release began
// Modports:
//   master : the sequencer (reads locked, drives everything else)
//   slave  : the consumer side (drives locked, reads the outputs)
// ---------------------------------------------------------------------------
interface clk_rst_seq_if #(
  parameter int NUM_DOM = 3
);
  logic               locked;
  logic [NUM_DOM-1:0] rst_dom_n;
  logic               ready;
  logic               ce_out;
  logic               lock_lost;

  modport master (
    input  locked,
    output rst_dom_n,
    output ready,
    output ce_out,
    output lock_lost
  );

  modport slave (
    output locked,
    input  rst_dom_n,
    input  ready,
    input  ce_out,
    input  lock_lost
  );
endinterface

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
// Startup sequencer for the board clock. Waits for LOCK_WAIT consecutive
// synchronized lock cycles, then releases NUM_DOM active-low domain resets
// one every STAGGER cycles (domain 0 first), raises ready with the last one,
// and afterwards emits a one-cycle ce_out strobe every DIV cycles.
//
// Ports:
//   clk    : 200 MHz clock from the clock buffer
//   rst_n  : asynchronous active-low reset
//   bus    : clk_rst_seq_if.master (locked in; rst_dom_n, ready, ce_out,
//            lock_lost out). All outputs are registered.
//
// Build option:
//   CLK_RST_SEQ_RELOCK_EN : when defined, a lock loss after release has begun
//   re-asserts every domain reset, clears ready/ce_out and restarts the whole
//   sequence. When undefined, a lock loss after release only sets lock_lost.
// ---------------------------------------------------------------------------
module clk_rst_seq #(
  parameter int LOCK_WAIT = 1024,
  parameter int NUM_DOM   = 3,
  parameter int STAGGER   = 16,
  parameter int DIV       = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_rst_seq_if.master bus
);

`ifdef CLK_RST_SEQ_RELOCK_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  localparam int LW_W  = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam int ST_W  = (STAGGER > 1)   ? $clog2(STAGGER)   : 1;
  localparam int DOM_W = (NUM_DOM > 1)   ? $clog2(NUM_DOM)   : 1;
  localparam int DIV_W = (DIV > 1)       ? $clog2(DIV)       : 1;

  localparam logic [LW_W-1:0]  LW_LAST  = LW_W'(LOCK_WAIT - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STAGGER - 1);
  localparam logic [DOM_W-1:0] DOM_LAST = DOM_W'(NUM_DOM - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [1:0]         lock_sync_r;
  logic               locked_s;
  state_t             state_r;
  logic [LW_W-1:0]    stable_cnt_r;
  logic [ST_W-1:0]    stagger_cnt_r;
  logic [DOM_W-1:0]   dom_idx_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [NUM_DOM-1:0] rst_dom_r;
  logic               ready_r;
  logic               ce_r;
  logic               lock_lost_r;

  logic               first_rel_s;
  logic               lock_drop_s;
  logic [DIV_W-1:0]   div_next_s;

  // Two-flop synchronizer for the asynchronous MMCM lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], bus.locked};
    end
  end

  assign locked_s = lock_sync_r[1];

  // Release-start, lock-drop and divider-wrap decodes from registered state.
  always_comb begin
    first_rel_s = 1'b0;
    lock_drop_s = 1'b0;
    div_next_s  = DIV_W'(0);
    // The WAIT_LOCK edge that first sees lock counts as locked cycle 1, so
    // the LOCK_WAIT-th consecutive locked cycle is the release edge.
    if (locked_s && (state_r == WAIT_LOCK) && (LOCK_WAIT == 1)) begin
      first_rel_s = 1'b1;
    end else if (locked_s && (state_r == STABLE) && (stable_cnt_r == LW_LAST)) begin
      first_rel_s = 1'b1;
    end else begin
      first_rel_s = 1'b0;
    end
    if (!locked_s && ((state_r == RELEASE) || (state_r == RUN))) begin
      lock_drop_s = 1'b1;
    end else begin
      lock_drop_s = 1'b0;
    end
    if (div_cnt_r == DIV_LAST) begin
      div_next_s = DIV_W'(0);
    end else begin
      div_next_s = div_cnt_r + DIV_W'(1);
    end
  end

  // Sequencer FSM with all outputs and counters registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= WAIT_LOCK;
      stable_cnt_r  <= LW_W'(0);
      stagger_cnt_r <= ST_W'(0);
      dom_idx_r     <= DOM_W'(0);
      div_cnt_r     <= DIV_W'(0);
      rst_dom_r     <= NUM_DOM'(0);
      ready_r       <= 1'b0;
      ce_r          <= 1'b0;
      lock_lost_r   <= 1'b0;
    end else begin
      // Sticky: only rst_n clears it.
      if (lock_drop_s) begin
        lock_lost_r <= 1'b1;
      end else begin
        lock_lost_r <= lock_lost_r;
      end

      if (RELOCK_EN && lock_drop_s) begin
        state_r       <= WAIT_LOCK;
        stable_cnt_r  <= LW_W'(0);
        stagger_cnt_r <= ST_W'(0);
        dom_idx_r     <= DOM_W'(0);
        div_cnt_r     <= DIV_W'(0);
        rst_dom_r     <= NUM_DOM'(0);
        ready_r       <= 1'b0;
        ce_r          <= 1'b0;
      end else if (first_rel_s) begin
        // Domain 0 comes out of reset on the same edge as the lock decision.
        rst_dom_r     <= NUM_DOM'(1);
        stable_cnt_r  <= LW_W'(0);
        stagger_cnt_r <= ST_W'(0);
        dom_idx_r     <= DOM_W'(1);
        div_cnt_r     <= DIV_W'(0);
        ce_r          <= 1'b0;
        if (NUM_DOM == 1) begin
          ready_r <= 1'b1;
          state_r <= RUN;
        end else begin
          ready_r <= 1'b0;
          state_r <= RELEASE;
        end
      end else begin
        case (state_r)
          WAIT_LOCK: begin
            if (locked_s) begin
              state_r      <= STABLE;
              stable_cnt_r <= LW_W'(1);
            end else begin
              stable_cnt_r <= LW_W'(0);
            end
          end
          STABLE: begin
            if (locked_s) begin
              stable_cnt_r <= stable_cnt_r + LW_W'(1);
            end else begin
              state_r      <= WAIT_LOCK;
              stable_cnt_r <= LW_W'(0);
            end
          end
          RELEASE: begin
            if (stagger_cnt_r == ST_LAST) begin
              stagger_cnt_r <= ST_W'(0);
              rst_dom_r     <= rst_dom_r | (NUM_DOM'(1) << dom_idx_r);
              if (dom_idx_r == DOM_LAST) begin
                ready_r   <= 1'b1;
                state_r   <= RUN;
                div_cnt_r <= DIV_W'(0);
                ce_r      <= 1'b0;
              end else begin
                dom_idx_r <= dom_idx_r + DOM_W'(1);
              end
            end else begin
              stagger_cnt_r <= stagger_cnt_r + ST_W'(1);
            end
          end
          RUN: begin
            // ce_r is registered from the next divider value, so it is high
            // exactly while the divider counter sits at DIV-1.
            div_cnt_r <= div_next_s;
            ce_r      <= (div_next_s == DIV_LAST);
          end
          default: begin
            state_r       <= WAIT_LOCK;
            stable_cnt_r  <= LW_W'(0);
            stagger_cnt_r <= ST_W'(0);
            dom_idx_r     <= DOM_W'(0);
            div_cnt_r     <= DIV_W'(0);
            rst_dom_r     <= NUM_DOM'(0);
            ready_r       <= 1'b0;
            ce_r          <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rst_dom_n = rst_dom_r;
  assign bus.ready     = ready_r;
  assign bus.ce_out    = ce_r;
  assign bus.lock_lost = lock_lost_r;

endmodule
